pwm_fade_ctrl: RTL

Sequencing controller for the PWM datapath. It owns the PWM period counter and drives the `duty` and `max_value` inputs of a `pwm_module` instance. On a start command it ramps `duty` from its present value to a target value in fixed steps, one step every N PWM periods. Duty changes occur only at period boundaries, so no output period is ever truncated or glitched.

---
 rtl/pwm_ctrl_pkg.sv | 31 +++
 rtl/pwm_period_counter.sv | 31 +++
 rtl/pwm_fade_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and the saturating duty-step helper for the PWM sequencers.
package pwm_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } fade_state_t;

   localparam int DEF_BIT_WIDTH  = 8;
   localparam int DEF_RATE_WIDTH = 8;

   // The helper works on a fixed wide word; callers zero-extend and truncate, so any
   // bit_width up to 31 gets a difference at least one bit wider than the operands.
   localparam int FADE_W = 32;

   function automatic logic [FADE_W-1:0] fade_step(input logic [FADE_W-1:0] duty,
                                                   input logic [FADE_W-1:0] tgt,
                                                   input logic [FADE_W-1:0] step);
      logic [FADE_W:0]   diff;
      logic [FADE_W-1:0] res;
      if (tgt >= duty) begin
         diff = {1'b0, tgt} - {1'b0, duty};
         res  = (diff <= {1'b0, step}) ? tgt : duty + step;
      end else begin
         diff = {1'b0, duty} - {1'b0, tgt};
         res  = (diff <= {1'b0, step}) ? tgt : duty - step;
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: 0..max_value then wrap, with a combinational period_end flag.
module pwm_period_counter
   import pwm_ctrl_pkg::*;
#(
   parameter int bit_width = DEF_BIT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [bit_width-1:0] max_value,
   output logic                 period_end
);

   logic [bit_width-1:0] cnt_q;
   logic [bit_width-1:0] cnt_d;

   // Using >= lets a lowered max_value pull an overshooting counter back to 0 at once.
   always_comb begin
      cnt_d = (cnt_q >= max_value) ? '0 : cnt_q + 1'b1;
   end

   assign period_end = (cnt_q == max_value);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty ramp sequencer for pwm_module; duty only moves on period boundaries.
// Optional feature: define PWM_FADE_RETARGET_EN to let start re-target a running ramp.
module pwm_fade_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int bit_width  = DEF_BIT_WIDTH,
   parameter int rate_width = DEF_RATE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [bit_width-1:0]  target,
   input  logic [bit_width-1:0]  step,
   input  logic [rate_width-1:0] rate,
   input  logic [bit_width-1:0]  max_value,
   output logic [bit_width-1:0]  duty,
   output logic                  period_end,
   output logic                  busy,
   output logic                  done
);

`ifdef PWM_FADE_RETARGET_EN
   localparam bit RETARGET_EN = 1'b1;
`else
   localparam bit RETARGET_EN = 1'b0;
`endif

   fade_state_t           state_q, state_d;
   logic [bit_width-1:0]  duty_q, duty_d;
   logic [bit_width-1:0]  tgt_q, tgt_d;
   logic [bit_width-1:0]  step_q, step_d;
   logic [rate_width-1:0] rate_q, rate_d;
   logic [rate_width-1:0] rate_cnt_q, rate_cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [bit_width-1:0]  step_nz;

   pwm_period_counter #(
      .bit_width (bit_width)
   ) u_period_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .max_value  (max_value),
      .period_end (period_end)
   );

   assign step_nz = (step == '0) ? {{(bit_width-1){1'b0}}, 1'b1} : step;

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      rate_d     = rate_q;
      rate_cnt_d = rate_cnt_q;
      done_d     = 1'b0;

      if (abort) begin
         state_d    = ST_IDLE;
         rate_cnt_d = '0;
      end else if (start && (state_q == ST_IDLE || RETARGET_EN)) begin
         // A start that matches the present duty finishes immediately without ramping.
         tgt_d      = target;
         step_d     = step_nz;
         rate_d     = rate;
         rate_cnt_d = rate;
         if (target == duty_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RAMP;
         end
      end else if (state_q == ST_RAMP && period_end) begin
         if (rate_cnt_q != '0) begin
            rate_cnt_d = rate_cnt_q - 1'b1;
         end else begin
            duty_d     = bit_width'(fade_step(FADE_W'(duty_q), FADE_W'(tgt_q), FADE_W'(step_q)));
            rate_cnt_d = rate_q;
            if (duty_d == tgt_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      end

      busy_d = (state_d == ST_RAMP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         duty_q     <= '0;
         tgt_q      <= '0;
         step_q     <= '0;
         rate_q     <= '0;
         rate_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         rate_q     <= rate_d;
         rate_cnt_q <= rate_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign duty = duty_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
